// File: rtl/fir_pkg.sv
// fir_pkg
//   Shared definitions for the FIR input sequencer: the sequencer state
//   encoding and the default filter geometry (sample width, coefficient
//   width, tap count, FIFO depth, cycles per filter sample).
//   Ports: none (package).
package fir_pkg;

    localparam int X_N_SIZE    = 8;
    localparam int TAP_SIZE    = 3;
    localparam int NBR_OF_TAPS = 3;
    localparam int FIFO_DEPTH  = 4;
    // GET_DATA + 4 x CALC + SET_OUTPUT in the filter core
    localparam int FIR_PERIOD  = 6;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_STREAM,
        ST_CFG_COLLECT,
        ST_CFG_REQ,
        ST_CFG_SHIFT
    } state_e;

endpackage

// File: rtl/fir_in_ctrl_if.sv
// fir_in_ctrl_if
//   Bundles the pad-side strobes and the filter-side stream of the FIR
//   input sequencer.
//   Signals:
//     in_data / in_valid / cfg_start : pad -> sequencer
//     x_n / s_axis_fir_tvalid / s_set_coeffs : sequencer -> filter
//   Modports: master (pad/filter environment), slave (sequencer).
interface fir_in_ctrl_if #(
    parameter int X_N_SIZE = fir_pkg::X_N_SIZE
) ();

    logic [X_N_SIZE-1:0] in_data;
    logic                in_valid;
    logic                cfg_start;
    logic [X_N_SIZE-1:0] x_n;
    logic                s_axis_fir_tvalid;
    logic                s_set_coeffs;

    modport master (
        output in_data, in_valid, cfg_start,
        input  x_n, s_axis_fir_tvalid, s_set_coeffs
    );

    modport slave (
        input  in_data, in_valid, cfg_start,
        output x_n, s_axis_fir_tvalid, s_set_coeffs
    );

endinterface

// File: rtl/fir_in_fifo.sv
// fir_in_fifo
//   Synchronous sample FIFO with a combinational read head.
//   Ports:
//     clk, rst_n : clock, asynchronous active-low reset
//     push, din  : write request and data (dropped when full and not popping)
//     pop        : consume head (ignored when empty)
//     head       : current head entry
//     full/empty : occupancy flags
//     drop       : push was discarded this cycle
module fir_in_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic [WIDTH-1:0] din,
    input  logic             pop,
    output logic [WIDTH-1:0] head,
    output logic             full,
    output logic             empty,
    output logic             drop
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] mem_d [DEPTH];
    logic [AW:0]      wr_ptr_q, wr_ptr_d;
    logic [AW:0]      rd_ptr_q, rd_ptr_d;
    logic             do_push, do_pop;

    // Extra pointer MSB distinguishes full from empty.
    assign empty = (wr_ptr_q == rd_ptr_q);
    assign full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                   (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    assign head  = mem_q[rd_ptr_q[AW-1:0]];

    // A simultaneous pop frees the slot, so a push while full still lands.
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);
    assign drop    = push && !do_push;

    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (do_push) begin
            mem_d[wr_ptr_q[AW-1:0]] = din;
            wr_ptr_d = wr_ptr_q + 1'b1;
        end
        if (do_pop) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mem_q    <= '{default: '0};
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            mem_q    <= mem_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

endmodule

// File: rtl/fir_in_ctrl.sv
// fir_in_ctrl
//   Input sequencer in front of the FIR core. Buffers pad samples in a
//   FIFO and presents one every FIR_PERIOD cycles, and runs the
//   coefficient-load protocol so coeff[0] ends up in filter tap 0.
//   Ports:
//     clk, rst_n : clock, asynchronous active-low reset
//     bus        : fir_in_ctrl_if.slave (in_data/in_valid/cfg_start in,
//                  x_n/s_axis_fir_tvalid/s_set_coeffs out, all registered)
//     busy       : state is not IDLE
//     fifo_full  : FIFO holds FIFO_DEPTH entries
//     drop_cnt   : saturating count of dropped words (FIR_IN_DROP_CNT_EN only)
//   Build option: define FIR_IN_DROP_CNT_EN to add drop_cnt.
module fir_in_ctrl #(
    parameter int X_N_SIZE    = fir_pkg::X_N_SIZE,
    parameter int TAP_SIZE    = fir_pkg::TAP_SIZE,
    parameter int NBR_OF_TAPS = fir_pkg::NBR_OF_TAPS,
    parameter int FIFO_DEPTH  = fir_pkg::FIFO_DEPTH,
    parameter int FIR_PERIOD  = fir_pkg::FIR_PERIOD
) (
    input  logic        clk,
    input  logic        rst_n,
    fir_in_ctrl_if.slave bus,
    output logic        busy,
    output logic        fifo_full
`ifdef FIR_IN_DROP_CNT_EN
    ,
    output logic [7:0]  drop_cnt
`endif
);

    import fir_pkg::*;

    localparam int CNT_W = (FIR_PERIOD > 1) ? $clog2(FIR_PERIOD) : 1;
    localparam int TAP_W = (NBR_OF_TAPS > 1) ? $clog2(NBR_OF_TAPS) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(FIR_PERIOD - 1);
    localparam logic [TAP_W-1:0] TAP_LAST = TAP_W'(NBR_OF_TAPS - 1);

    function automatic logic [X_N_SIZE-1:0] sext(input logic [TAP_SIZE-1:0] c);
        return {{(X_N_SIZE-TAP_SIZE){c[TAP_SIZE-1]}}, c};
    endfunction

    state_e              state_q, state_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [TAP_W-1:0]    tap_q, tap_d;   // collect index k, then shift index j
    logic [TAP_SIZE-1:0] coeff_q [NBR_OF_TAPS];
    logic [TAP_SIZE-1:0] coeff_d [NBR_OF_TAPS];
    logic [X_N_SIZE-1:0] x_n_q, x_n_d;
    logic                tvalid_q, tvalid_d;
    logic                set_q, set_d;

    logic                push, pop, empty, drop;
    logic [X_N_SIZE-1:0] head;

    assign push = bus.in_valid && (state_q != ST_CFG_COLLECT);

    fir_in_fifo #(
        .WIDTH (X_N_SIZE),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (push),
        .din   (bus.in_data),
        .pop   (pop),
        .head  (head),
        .full  (fifo_full),
        .empty (empty),
        .drop  (drop)
    );

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        tap_d    = tap_q;
        coeff_d  = coeff_q;
        x_n_d    = x_n_q;
        tvalid_d = tvalid_q;
        set_d    = set_q;
        pop      = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                if (bus.cfg_start) begin
                    state_d = ST_CFG_COLLECT;
                    tap_d   = '0;
                end else if (!empty) begin
                    pop      = 1'b1;
                    x_n_d    = head;
                    tvalid_d = 1'b1;
                    cnt_d    = '0;
                    state_d  = ST_STREAM;
                end
            end
            ST_STREAM: begin
                if (cnt_q == CNT_LAST) begin
                    cnt_d = '0;
                    if (!empty) begin
                        pop   = 1'b1;
                        x_n_d = head;
                    end else begin
                        tvalid_d = 1'b0;
                        state_d  = ST_IDLE;
                    end
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            ST_CFG_COLLECT: begin
                if (bus.in_valid) begin
                    coeff_d[tap_q] = bus.in_data[TAP_SIZE-1:0];
                    if (tap_q == TAP_LAST) begin
                        tap_d   = '0;
                        x_n_d   = '0;
                        set_d   = 1'b1;
                        state_d = ST_CFG_REQ;
                    end else begin
                        tap_d = tap_q + 1'b1;
                    end
                end
            end
            ST_CFG_REQ: begin
                // Highest tap first: the filter shifts, so coeff[0] must go last.
                tap_d   = '0;
                x_n_d   = sext(coeff_q[TAP_LAST]);
                set_d   = (NBR_OF_TAPS > 1);
                state_d = ST_CFG_SHIFT;
            end
            ST_CFG_SHIFT: begin
                if (tap_q == TAP_LAST) begin
                    tap_d   = '0;
                    set_d   = 1'b0;
                    state_d = ST_IDLE;
                end else begin
                    tap_d = tap_q + 1'b1;
                    x_n_d = sext(coeff_q[TAP_LAST - tap_q - TAP_W'(1)]);
                    set_d = ((tap_q + TAP_W'(1)) != TAP_LAST);
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= ST_IDLE;
            cnt_q    <= '0;
            tap_q    <= '0;
            coeff_q  <= '{default: '0};
            x_n_q    <= '0;
            tvalid_q <= 1'b0;
            set_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            tap_q    <= tap_d;
            coeff_q  <= coeff_d;
            x_n_q    <= x_n_d;
            tvalid_q <= tvalid_d;
            set_q    <= set_d;
        end
    end

    assign bus.x_n               = x_n_q;
    assign bus.s_axis_fir_tvalid = tvalid_q;
    assign bus.s_set_coeffs      = set_q;
    assign busy                  = (state_q != ST_IDLE);

`ifdef FIR_IN_DROP_CNT_EN
    logic [7:0] drop_cnt_q, drop_cnt_d;

    always_comb begin
        drop_cnt_d = drop_cnt_q;
        if (drop && (drop_cnt_q != 8'hFF)) begin
            drop_cnt_d = drop_cnt_q + 8'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            drop_cnt_q <= '0;
        end else begin
            drop_cnt_q <= drop_cnt_d;
        end
    end

    assign drop_cnt = drop_cnt_q;
`else
    logic drop_unused;
    assign drop_unused = drop;
`endif

endmodule

// File: doc/fir_in_ctrl.md
# fir_in_ctrl

Input sequencer directly upstream of the FIR filter core. Accepts byte-wide sample/coefficient strobes from the pad interface, buffers samples in a small FIFO and presents them to the filter at the filter's fixed processing rate (`s_axis_fir_tvalid`, `x_n`). Runs the coefficient-load protocol (`s_set_coeffs`) so the filter's tap registers are written in the correct order.

## Interface
- `X_N_SIZE`, 8, sample width; matches the filter.
- `TAP_SIZE`, 3, coefficient width; matches the filter.
- `NBR_OF_TAPS`, 3, number of coefficients per load.
- `FIFO_DEPTH`, 4, sample FIFO entries; power of two.
- `FIR_PERIOD`, 6, cycles per filter sample (GET_DATA + 4×CALC + SET_OUTPUT).
- `clk` in 1: single clock.
- `rst_n` in 1: reset, asynchronous, active-low.
- `in_data` in X_N_SIZE: sample or coefficient word.
- `in_valid` in 1: one-cycle strobe qualifying `in_data`; no backpressure.
- `cfg_start` in 1: one-cycle request to begin a coefficient load.
- `x_n` out X_N_SIZE: registered word to filter.
- `s_axis_fir_tvalid` out 1: registered stream-valid to filter.
- `s_set_coeffs` out 1: registered coefficient-load request to filter.
- `busy` out 1: high in any state other than IDLE.
- `fifo_full` out 1: FIFO holds FIFO_DEPTH entries.

## Operation
- Reset: all outputs 0, FIFO empty, coefficient regs 0, state IDLE, counters 0.
- FIFO: `in_valid` pushes `in_data` unless in CFG_COLLECT. Push while full drops the word. Push and pop in the same cycle when full: both succeed.
- States: IDLE, STREAM, CFG_COLLECT, CFG_REQ, CFG_SHIFT.
- IDLE: `cfg_start` → CFG_COLLECT (priority). Otherwise, FIFO non-empty → STREAM: pop head into `x_n`, `tvalid`=1, period counter=0.
- STREAM: period counter counts 0..FIR_PERIOD-1. At FIR_PERIOD-1:
  - FIFO non-empty: pop next into `x_n`, counter wraps to 0.
  - FIFO empty: `tvalid`=0, `x_n` held, → IDLE.
  - `cfg_start` in STREAM is ignored.
- CFG_COLLECT: each `in_valid` writes `in_data[TAP_SIZE-1:0]` to `coeff[k]`, k=0..NBR_OF_TAPS-1. After the last word → CFG_REQ.
- CFG_REQ: one cycle, `s_set_coeffs`=1, `x_n`=0 → CFG_SHIFT.
- CFG_SHIFT: NBR_OF_TAPS cycles, cycle j drives `x_n` = sign-extended `coeff[NBR_OF_TAPS-1-j]`. `s_set_coeffs`=1 for j<NBR_OF_TAPS-1 and 0 on the last cycle, then → IDLE. Net effect: `coeff[0]` lands in filter tap 0.
- `tvalid`=0 in all CFG states.

## Timing
- All outputs registered; a state change shows on the outputs on the same edge.
- First sample: `in_valid` at cycle t in IDLE (FIFO empty) → push at t+1 → `tvalid`=1 with `x_n`=sample at t+2.
- Each sample is held on `x_n` for exactly FIR_PERIOD cycles.
- Coefficient load: last collect strobe at t → `s_set_coeffs` high t+1..t+NBR_OF_TAPS, low at t+NBR_OF_TAPS+1. That is 1+NBR_OF_TAPS cycles of CFG_REQ/CFG_SHIFT.
- Reset mid-operation: immediate clear; the filter sees `tvalid`=`s_set_coeffs`=0 asynchronously.

## Configuration
- `FIR_IN_DROP_CNT_EN`: adds output `drop_cnt` [7:0], a saturating count of words dropped at FIFO-full. Reset 0, holds at 255.
- Without the macro: no port and no counter; drops are silent.

## Structure
- Package `fir_pkg`: state enum, FIR_PERIOD, shared X_N_SIZE/TAP_SIZE/NBR_OF_TAPS defaults.
- Sub-module `fir_in_fifo`: synchronous FIFO with push/pop/full/empty, one-cycle read head. The FSM and coefficient registers stay in the top.

## Test plan
- Reset: drive `rst_n`=0 mid-STREAM → all outputs 0 the same cycle, FIFO empty after release.
- Stream: strobe 0x05, 0xFB, 0x7F spaced 2 cycles apart → `x_n` = 0x05, 0xFB, 0x7F, each held 6 cycles, `tvalid` continuous, then 0 → IDLE.
- Overflow: strobe 6 words back-to-back from IDLE → first 5 accepted (one popped immediately), 6th dropped, `fifo_full`=1; `drop_cnt`=1 with macro.
- Coefficients: `cfg_start`, then words 0x01, 0x02, 0x03 → `s_set_coeffs` 1,1,1,0 with `x_n` 0x00, 0x03, 0x02, 0x01 (sign-extended), then IDLE.
- Priority: `cfg_start` and `in_valid` (0x10) in the same IDLE cycle → CFG_COLLECT entered, 0x10 stored in FIFO and streamed after the load completes.
